mem_port_arb: RTL

//  Shares one single-port synchronous memory between instruction fetch (IF) and the

---
 rtl/mem_port_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
//
// Shares one single-port synchronous memory between instruction fetch (IF) and
// the data path (LOAD/STORE). One requester is granted per cycle. The grant is
// combinational, so the granted request drives the memory port in the same
// cycle. In-flight reads are tracked in a tag pipeline so that each read's data
// is returned to the port that issued it, RD_LAT cycles after the grant.
//
// Parameters
//   AW      address width (byte address)
//   RD_LAT  memory read latency in cycles, 1 or 2
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req/if_addr            fetch read request, held until if_gnt
//   if_gnt                    fetch request accepted this cycle
//   if_rvalid/if_rdata        fetch read response
//   d_req/d_we/d_be/d_addr/d_wdata
//                             data request (load or store), held until d_gnt
//   d_gnt                     data request accepted this cycle
//   d_rvalid/d_rdata          load response
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                             memory port, driven by the granted request
//   mem_rdata                 memory read data, RD_LAT cycles after a read
//
// Configuration
//   ROUND_ROBIN_EN  when defined, simultaneous requests alternate between the
//                   two requesters (data wins the first contention after
//                   reset). When undefined, data always beats fetch.
// -----------------------------------------------------------------------------
module mem_port_arb #(
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // pick_d: when data is requesting, does data win this cycle
  logic              pick_d;
  logic              rd_push;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_own;
  logic              tail_vld;
  logic              tail_own;

`ifdef ROUND_ROBIN_EN
  // last_d remembers who won the previous contention; only contention moves it
  logic last_d;

  always_comb begin
    if (d_req && if_req) pick_d = !last_d;
    else                 pick_d = d_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last_d <= 1'b0;
    else if (d_req && if_req) last_d <= !last_d;
  end
`else
  assign pick_d = d_req;
`endif

  // Grants are forced low during reset so the memory port is idle as well
  assign d_gnt  = !rst && d_req && pick_d;
  assign if_gnt = !rst && if_req && !pick_d;

  // Every granted read occupies one pipeline slot; stores push an empty slot
  assign rd_push = if_gnt || (d_gnt && !d_we);

  // Memory port mux: the granted request drives the port, idle port is all 0
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'hF;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : 32'h0;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
    end
  end

  // Tag pipeline: slot 0 is the read granted last cycle, the tail slot lines
  // up with mem_rdata. tag_own is 1 for data, 0 for fetch.
  generate
    if (RD_LAT > 1) begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_vld <= '0;
          tag_own <= '0;
        end else begin
          tag_vld <= {tag_vld[RD_LAT-2:0], rd_push};
          tag_own <= {tag_own[RD_LAT-2:0], d_gnt};
        end
      end
    end else begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_vld <= '0;
          tag_own <= '0;
        end else begin
          tag_vld <= rd_push;
          tag_own <= d_gnt;
        end
      end
    end
  endgenerate

  assign tail_vld = tag_vld[RD_LAT-1];
  assign tail_own = tag_own[RD_LAT-1];

  // Response routing; rdata is zero whenever its rvalid is low
  assign if_rvalid = tail_vld && !tail_own;
  assign d_rvalid  = tail_vld && tail_own;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule
